// File: rtl/instruction_memory_ctrl.sv
// Instruction memory with a valid/ready loader port, a pipelined read port
// (1 or 2 cycle latency) and a post-reset clear sweep that fills it with FILL_VALUE.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   writeValid/writeReady   loader handshake; writeAddr/writeData
//   readEnable, readAddr    fetch request
//   readData, readValid     response word and one-cycle strobe per request
//   initDone                sweep finished, memory usable
module instruction_memory_ctrl #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 13,
    parameter int                    RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int                    READ_LATENCY   = 1,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE     = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  writeValid,
    output logic                  writeReady,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  readEnable,
    input  logic [ADDR_WIDTH-1:0] readAddr,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  readValid,
    output logic                  initDone
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clearAddr;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  clearing;
    logic                  writeFire;
    logic                  readFire;
    logic [DATA_WIDTH-1:0] readWord;

    // writeReady is only ever high in IDLE, so it alone qualifies a write.
    assign clearing  = (state == CLEAR) && !reset;
    assign writeFire = writeValid && writeReady;
    assign readFire  = readEnable && (state == IDLE);

    // Write-first: a read colliding with an accepted write sees the new word.
    assign readWord = (writeFire && (writeAddr == readAddr)) ? writeData
                                                             : mem[readAddr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= CLEAR_ON_RESET ? CLEAR : IDLE;
            initDone   <= !CLEAR_ON_RESET;
            writeReady <= 1'b0;
            clearAddr  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clearAddr <= clearAddr + ADDR_WIDTH'(1);
                    if (clearAddr == LAST_ADDR) begin
                        state      <= IDLE;
                        initDone   <= 1'b1;
                        writeReady <= 1'b1;
                    end
                end
                IDLE: begin
                    writeReady <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Contents are deliberately not reset; the sweep takes care of that.
    always_ff @(posedge clock) begin
        if (clearing) begin
            mem[clearAddr] <= FILL_VALUE;
        end else if (writeFire) begin
            mem[writeAddr] <= writeData;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : gLat2
            logic                  stageValid;
            logic [DATA_WIDTH-1:0] stageData;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    stageValid <= 1'b0;
                    stageData  <= '0;
                    readValid  <= 1'b0;
                    readData   <= '0;
                end else begin
                    stageValid <= readFire;
                    if (readFire) begin
                        stageData <= readWord;
                    end
                    readValid <= stageValid;
                    if (stageValid) begin
                        readData <= stageData;
                    end
                end
            end
        end else begin : gLat1
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    readValid <= 1'b0;
                    readData  <= '0;
                end else begin
                    readValid <= readFire;
                    if (readFire) begin
                        readData <= readWord;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_instruction_memory_ctrl.sv
// Bench for instruction_memory_ctrl: three instances (latency 1 / latency 2
// with clear sweep, latency 1 without) driven by shared inputs.
module tb_instruction_memory_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] FILL = 32'h0000_0013;

    logic          clock = 1'b0;
    logic          reset;
    logic          writeValid;
    logic [AW-1:0] writeAddr;
    logic [DW-1:0] writeData;
    logic          readEnable;
    logic [AW-1:0] readAddr;

    logic [DW-1:0] rd [3];
    logic          rv [3];
    logic          wr [3];
    logic          id [3];

    always #5 clock = ~clock;

    instruction_memory_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
        .CLEAR_ON_RESET(1'b1), .FILL_VALUE(FILL)
    ) dutA (
        .clock(clock), .reset(reset),
        .writeValid(writeValid), .writeReady(wr[0]),
        .writeAddr(writeAddr), .writeData(writeData),
        .readEnable(readEnable), .readAddr(readAddr),
        .readData(rd[0]), .readValid(rv[0]), .initDone(id[0])
    );

    instruction_memory_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2),
        .CLEAR_ON_RESET(1'b1), .FILL_VALUE(FILL)
    ) dutB (
        .clock(clock), .reset(reset),
        .writeValid(writeValid), .writeReady(wr[1]),
        .writeAddr(writeAddr), .writeData(writeData),
        .readEnable(readEnable), .readAddr(readAddr),
        .readData(rd[1]), .readValid(rv[1]), .initDone(id[1])
    );

    instruction_memory_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
        .CLEAR_ON_RESET(1'b0), .FILL_VALUE(FILL)
    ) dutC (
        .clock(clock), .reset(reset),
        .writeValid(writeValid), .writeReady(wr[2]),
        .writeAddr(writeAddr), .writeData(writeData),
        .readEnable(readEnable), .readAddr(readAddr),
        .readData(rd[2]), .readValid(rv[2]), .initDone(id[2])
    );

    // Reference model: word array, sweep countdown and a queue of
    // responses tagged with the edge number at which they must appear.
    typedef struct {
        int          due;
        logic [31:0] data;
        bit          known;
    } resp_t;

    int          lat [3] = '{1, 2, 1};
    bit          clr [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] mMem [3][DEPTH];
    bit          mKnown [3][DEPTH];
    int          sweepLeft [3];
    bit          mReady [3];
    bit          mInit [3];
    bit          mValid [3];
    logic [31:0] mData [3];
    bit          mDataKnown [3];
    bit          fired [3];
    resp_t       pq [3][$];
    int          cyc = 0;

    int checks = 0;
    int failures = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 3; d++) begin
            sweepLeft[d]  = clr[d] ? DEPTH : 0;
            mReady[d]     = 1'b0;
            mInit[d]      = !clr[d];
            mValid[d]     = 1'b0;
            mData[d]      = '0;
            mDataKnown[d] = 1'b1;
            fired[d]      = 1'b0;
            pq[d].delete();
        end
    endtask

    task automatic modelEdge();
        resp_t r;
        bit    idle;
        if (reset) return;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            idle     = (sweepLeft[d] == 0);
            fired[d] = writeValid && mReady[d];
            if (readEnable && idle) begin
                r.due = cyc + lat[d] - 1;
                if (fired[d] && writeAddr == readAddr) begin
                    r.data  = writeData;
                    r.known = 1'b1;
                end else begin
                    r.data  = mMem[d][readAddr];
                    r.known = mKnown[d][readAddr];
                end
                pq[d].push_back(r);
            end
            if (fired[d]) begin
                mMem[d][writeAddr]   = writeData;
                mKnown[d][writeAddr] = 1'b1;
            end
            if (!idle) begin
                mMem[d][DEPTH - sweepLeft[d]]   = FILL;
                mKnown[d][DEPTH - sweepLeft[d]] = 1'b1;
                sweepLeft[d]--;
            end
            mReady[d] = (sweepLeft[d] == 0);
            if (sweepLeft[d] == 0) mInit[d] = 1'b1;
            mValid[d] = 1'b0;
            if (pq[d].size() > 0 && pq[d][0].due == cyc) begin
                mValid[d]     = 1'b1;
                mData[d]      = pq[d][0].data;
                mDataKnown[d] = pq[d][0].known;
                void'(pq[d].pop_front());
            end
        end
    endtask

    task automatic checkAll();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("writeReady%0d@%0d", d, cyc), wr[d], mReady[d]);
            chk($sformatf("initDone%0d@%0d", d, cyc), id[d], mInit[d]);
            chk($sformatf("readValid%0d@%0d", d, cyc), rv[d], mValid[d]);
            if (mDataKnown[d])
                chk($sformatf("readData%0d@%0d", d, cyc), rd[d], mData[d]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        modelEdge();
        #1;
        checkAll();
    endtask

    initial begin
        int          lowCnt;
        int          cntA, cntB;
        logic [31:0] gotA [2];
        logic [31:0] gotB [2];

        for (int d = 0; d < 3; d++)
            for (int a = 0; a < DEPTH; a++) mKnown[d][a] = 1'b0;

        reset      = 1'b1;
        writeValid = 1'b0;
        writeAddr  = '0;
        writeData  = '0;
        readEnable = 1'b0;
        readAddr   = '0;
        modelReset();
        tick();
        tick();
        reset = 1'b0;

        // Sweep with a loader request held on addr 5 and random reads.
        writeValid = 1'b1;
        writeAddr  = 4'd5;
        writeData  = 32'h55AA_1234;
        lowCnt = (wr[0] == 1'b0) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            readEnable = 1'($urandom_range(0, 1));
            readAddr   = AW'($urandom_range(0, DEPTH - 1));
            tick();
            if (wr[0]) break;
            lowCnt++;
        end
        chk("sweepLowCycles", lowCnt, 16);
        chk("initDoneAfterSweep", id[0], 1'b1);
        readEnable = 1'b0;
        tick();
        chk("heldWriteAccepted", fired[0], 1'b1);
        writeValid = 1'b0;

        // Read every word back at both latencies.
        readEnable = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            readAddr = AW'(a);
            tick();
        end
        readEnable = 1'b0;
        tick();
        tick();

        // Two writes then back-to-back reads.
        writeValid = 1'b1;
        writeAddr  = 4'd3;
        writeData  = 32'hDEAD_BEEF;
        tick();
        writeAddr  = 4'd4;
        writeData  = 32'h1234_5678;
        tick();
        writeValid = 1'b0;
        cntA = 0;
        cntB = 0;
        for (int i = 0; i < 5; i++) begin
            readEnable = (i < 2);
            readAddr   = AW'(3 + i);
            tick();
            if (rv[0]) begin
                if (cntA < 2) gotA[cntA] = rd[0];
                cntA++;
            end
            if (rv[1]) begin
                if (cntB < 2) gotB[cntB] = rd[1];
                cntB++;
            end
        end
        chk("lat1ValidCount", cntA, 2);
        chk("lat2ValidCount", cntB, 2);
        if (cntA >= 2) begin
            chk("lat1First", gotA[0], 32'hDEAD_BEEF);
            chk("lat1Second", gotA[1], 32'h1234_5678);
        end
        if (cntB >= 2) begin
            chk("lat2First", gotB[0], 32'hDEAD_BEEF);
            chk("lat2Second", gotB[1], 32'h1234_5678);
        end

        // Same-edge write and read to one address.
        writeValid = 1'b1;
        writeAddr  = 4'd7;
        writeData  = 32'hCAFE_F00D;
        readEnable = 1'b1;
        readAddr   = 4'd7;
        tick();
        writeValid = 1'b0;
        readEnable = 1'b0;
        chk("collisionLat1", rd[0], 32'hCAFE_F00D);
        chk("collisionNoClear", rd[2], 32'hCAFE_F00D);
        tick();
        chk("collisionLat2", rd[1], 32'hCAFE_F00D);

        // The held write survived the sweep.
        readEnable = 1'b1;
        readAddr   = 4'd5;
        tick();
        readEnable = 1'b0;
        chk("heldWriteData", rd[0], 32'h55AA_1234);
        tick();

        // Random traffic with frequent collisions.
        for (int i = 0; i < 300; i++) begin
            writeValid = 1'($urandom_range(0, 1));
            writeAddr  = AW'($urandom_range(0, DEPTH - 1));
            writeData  = $urandom;
            readEnable = 1'($urandom_range(0, 1));
            readAddr   = ($urandom_range(0, 3) == 0) ? writeAddr
                                                     : AW'($urandom_range(0, DEPTH - 1));
            tick();
        end
        writeValid = 1'b0;
        readEnable = 1'b0;
        tick();
        tick();

        // Reset in the middle of a sweep restarts it from address 0.
        reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        chk("midSweepInitDone", id[0], 1'b0);
        tick();
        reset = 1'b0;
        lowCnt = (wr[0] == 1'b0) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            readEnable = 1'b1;
            readAddr   = AW'($urandom_range(0, DEPTH - 1));
            tick();
            if (rv[0] || rv[1]) break;
            if (wr[0]) break;
            lowCnt++;
        end
        chk("restartSweepLowCycles", lowCnt, 16);
        readAddr = 4'd9;
        tick();
        readEnable = 1'b0;
        chk("restartFill9", rd[0], FILL);
        tick();

        // Without the sweep, contents survive reset.
        writeValid = 1'b1;
        writeAddr  = 4'd2;
        writeData  = 32'hA5A5_A5A5;
        tick();
        writeValid = 1'b0;
        reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        chk("noClearInitDone", id[2], 1'b1);
        #1;
        reset = 1'b0;
        readEnable = 1'b1;
        readAddr   = 4'd2;
        tick();
        readEnable = 1'b0;
        chk("noClearRetainValid", rv[2], 1'b1);
        chk("noClearRetainData", rd[2], 32'hA5A5_A5A5);
        for (int i = 0; i < 18; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
